// File: rtl/addsub_sequencer_if.sv
// Request/response bundle for addsub_sequencer: two requesters in, one tagged response out.
// master = requester/consumer side, slave = the sequencer.
interface addsub_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_x0;
    logic [WIDTH-1:0] req_y0;
    logic [WIDTH-1:0] req_x1;
    logic [WIDTH-1:0] req_y1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_f;
    logic             rsp_ovf;
    logic             rsp_zero;

    modport master (
        output req_valid, req_op, req_x0, req_y0, req_x1, req_y1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_f, rsp_ovf, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_x0, req_y0, req_x1, req_y1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_f, rsp_ovf, rsp_zero
    );
endinterface

// File: rtl/addsub_sequencer.sv
// Round-robin shared add/sub sequencer around a single ripple adder (WIDTH must be 32).
// Build option: define ADDSUB_SEQ_FASTSUB_EN for single-pass subtraction (x + ~y + 1).
module addsub_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    addsub_sequencer_if.slave bus_if
);
    localparam logic [1:0] S_IDLE = 2'd0;
`ifndef ADDSUB_SEQ_FASTSUB_EN
    localparam logic [1:0] S_NEG  = 2'd1;
`endif
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Control and response state
    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Captured operands
    logic             op_q, op_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             y_sign_q, y_sign_d;

    logic [1:0]       grant;
    logic             win_id;
    logic             win_op;
    logic [WIDTH-1:0] win_x;
    logic [WIDTH-1:0] win_y;
    logic             handshake;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;

    function automatic logic [WIDTH-1:0] ripple_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cin
    );
        logic [WIDTH-1:0] s;
        logic             c;
        c = cin;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return s;
    endfunction

    // Grant only in IDLE and never while reset is held, so no handshake can be lost to reset.
    always_comb begin
        grant = 2'b00;
        if (state_q == S_IDLE && !rst) begin
            case (bus_if.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign handshake = |grant;
    assign win_id    = grant[1];
    assign win_op    = bus_if.req_op[win_id];
    assign win_x     = win_id ? bus_if.req_x1 : bus_if.req_x0;
    assign win_y     = win_id ? bus_if.req_y1 : bus_if.req_y0;

    always_comb begin
        add_a   = x_q;
        add_b   = b_q;
        add_cin = 1'b0;
`ifdef ADDSUB_SEQ_FASTSUB_EN
        if (op_q) begin
            add_b   = ~b_q;
            add_cin = 1'b1;
        end
`else
        if (state_q == S_NEG) begin
            add_a = ~b_q;
            add_b = {{(WIDTH-1){1'b0}}, 1'b1};
        end
`endif
    end

    assign sum = ripple_add(add_a, add_b, add_cin);

    // Overflow uses the original sign of y, so negating 0x80000000 (which wraps) is still right.
    assign sum_ovf = op_q
        ? ((x_q[WIDTH-1] != y_sign_q) && (sum[WIDTH-1] != x_q[WIDTH-1]))
        : ((x_q[WIDTH-1] == y_sign_q) && (sum[WIDTH-1] != x_q[WIDTH-1]));

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        rsp_id_d = rsp_id_q;
        f_d      = f_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        op_d     = op_q;
        id_d     = id_q;
        x_d      = x_q;
        b_d      = b_q;
        y_sign_d = y_sign_q;

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    op_d     = win_op;
                    id_d     = win_id;
                    x_d      = win_x;
                    b_d      = win_y;
                    y_sign_d = win_y[WIDTH-1];
                    ptr_d    = ~win_id;
`ifdef ADDSUB_SEQ_FASTSUB_EN
                    state_d  = S_ADD;
`else
                    state_d  = win_op ? S_NEG : S_ADD;
`endif
                end
            end
`ifndef ADDSUB_SEQ_FASTSUB_EN
            S_NEG: begin
                b_d     = sum;
                state_d = S_ADD;
            end
`endif
            S_ADD: begin
                f_d      = sum;
                ovf_d    = sum_ovf;
                zero_d   = (sum == '0);
                rsp_id_d = id_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (bus_if.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= 1'b0;
            rsp_id_q <= 1'b0;
            f_q      <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rsp_id_q <= rsp_id_d;
            f_q      <= f_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // NOTE: operand registers are always loaded at the handshake before being read, so they carry no reset.
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        id_q     <= id_d;
        x_q      <= x_d;
        b_q      <= b_d;
        y_sign_q <= y_sign_d;
    end

    assign bus_if.req_ready = grant;
    assign bus_if.rsp_valid = (state_q == S_RESP);
    assign bus_if.rsp_id    = rsp_id_q;
    assign bus_if.rsp_f     = f_q;
    assign bus_if.rsp_ovf   = ovf_q;
    assign bus_if.rsp_zero  = zero_q;
endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed self-checking bench for addsub_sequencer (honours ADDSUB_SEQ_FASTSUB_EN for sub latency).
module tb_addsub_sequencer;
    localparam int ADD_LAT = 2;
`ifdef ADDSUB_SEQ_FASTSUB_EN
    localparam int SUB_LAT = 2;
`else
    localparam int SUB_LAT = 3;
`endif

    localparam logic [31:0] SX [4] = '{32'd1, 32'h10, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    localparam logic [31:0] SY [4] = '{32'd2, 32'h20, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    localparam logic [31:0] SF [4] = '{32'd3, 32'h30, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    localparam logic        SO [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_sequencer_if bus ();

    addsub_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic op, input logic [31:0] x, input logic [31:0] y);
        bus.req_op[id] = op;
        if (id == 0) begin
            bus.req_x0 = x;
            bus.req_y0 = y;
        end else begin
            bus.req_x1 = x;
            bus.req_y1 = y;
        end
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        bus.req_valid = 2'b00;
        step();
        step();
        check({tag, ":req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, ":rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ":rsp_f"},     bus.rsp_f,          32'd0);
        check({tag, ":rsp_ovf"},   32'(bus.rsp_ovf),   32'd0);
        check({tag, ":rsp_zero"},  32'(bus.rsp_zero),  32'd0);
        check({tag, ":rsp_id"},    32'(bus.rsp_id),    32'd0);
        rst = 1'b0;
    endtask

    // Waits (bounded) for the grant, checks it is one-hot to id, then completes the handshake edge.
    task automatic handshake(input string tag, input int id, input bit keep);
        int n = 0;
        while (bus.req_ready[id] !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        check({tag, ":grant"}, 32'(bus.req_ready), (id == 0) ? 32'd1 : 32'd2);
        step();
        if (!keep) bus.req_valid[id] = 1'b0;
    endtask

    // Entered one cycle after the handshake cycle; reports cycles from handshake to rsp_valid.
    task automatic wait_rsp(input string tag, input int lat);
        int n = 1;
        while (bus.rsp_valid !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        check({tag, ":latency"}, 32'(n), 32'(lat));
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [31:0] f,
                             input logic ovf, input logic zero);
        check({tag, ":rsp_f"},    bus.rsp_f,          f);
        check({tag, ":rsp_ovf"},  32'(bus.rsp_ovf),   32'(ovf));
        check({tag, ":rsp_zero"}, 32'(bus.rsp_zero),  32'(zero));
        check({tag, ":rsp_id"},   32'(bus.rsp_id),    32'(id));
    endtask

    task automatic accept(input string tag);
        step();
        check({tag, ":released"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic single_op(input string tag, input logic op, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] f,
                             input logic ovf, input logic zero);
        drive(0, op, x, y);
        handshake(tag, 0, 1'b0);
        wait_rsp(tag, op ? SUB_LAT : ADD_LAT);
        check_rsp(tag, 1'b0, f, ovf, zero);
        accept(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int last_hs;
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_op    = 2'b00;
        bus.req_x0    = '0;
        bus.req_y0    = '0;
        bus.req_x1    = '0;
        bus.req_y1    = '0;
        bus.rsp_ready = 1'b0;
        last_hs       = 0;

        apply_reset("rst0");
        bus.rsp_ready = 1'b1;

        single_op("sub9_19",   1'b1, 32'd9,          32'd19,         32'hFFFF_FFF6, 1'b0, 1'b0);
        single_op("addmax",    1'b0, 32'h7FFF_FFFF, 32'd1,          32'h8000_0000, 1'b1, 1'b0);
        single_op("submin1",   1'b1, 32'h8000_0000, 32'd1,          32'h7FFF_FFFF, 1'b1, 1'b0);
        single_op("sub0min",   1'b1, 32'd0,          32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        single_op("sub5_5",    1'b1, 32'd5,          32'd5,          32'd0,         1'b0, 1'b1);
        single_op("addwrap",   1'b0, 32'hFFFF_FFFF, 32'd1,          32'd0,         1'b0, 1'b1);

        // Both requesters valid right after reset; requester 0 stays valid with a new op.
        apply_reset("rst1");
        drive(0, 1'b0, 32'd10,  32'd20);
        drive(1, 1'b1, 32'd100, 32'd1);
        handshake("arb0", 0, 1'b1);
        drive(0, 1'b0, 32'h4000_0000, 32'h4000_0000);
        wait_rsp("arb0", ADD_LAT);
        check_rsp("arb0", 1'b0, 32'd30, 1'b0, 1'b0);
        accept("arb0");
        handshake("arb1", 1, 1'b0);
        wait_rsp("arb1", SUB_LAT);
        check_rsp("arb1", 1'b1, 32'd99, 1'b0, 1'b0);
        accept("arb1");
        handshake("arb2", 0, 1'b0);
        wait_rsp("arb2", ADD_LAT);
        check_rsp("arb2", 1'b0, 32'h8000_0000, 1'b1, 1'b0);
        accept("arb2");

        // Back-pressure: response held for 5 cycles while requester 1 waits.
        bus.rsp_ready = 1'b0;
        drive(0, 1'b1, 32'd7, 32'd3);
        handshake("hold", 0, 1'b0);
        wait_rsp("hold", SUB_LAT);
        check_rsp("hold", 1'b0, 32'd4, 1'b0, 1'b0);
        drive(1, 1'b0, 32'd1, 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("hold%0d:rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("hold%0d:rsp_f", k),     bus.rsp_f,          32'd4);
            check($sformatf("hold%0d:rsp_id", k),    32'(bus.rsp_id),    32'd0);
            check($sformatf("hold%0d:req_ready", k), 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        step();
        check("hold:released", 32'(bus.rsp_valid), 32'd0);
        check("hold:idle_grant", 32'(bus.req_ready), 32'd2);
        handshake("hold_r1", 1, 1'b0);
        wait_rsp("hold_r1", ADD_LAT);
        check_rsp("hold_r1", 1'b1, 32'd2, 1'b0, 1'b0);
        accept("hold_r1");

        // Requester 1 streams adds; a handshake every 3 cycles.
        drive(1, 1'b0, SX[0], SY[0]);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (bus.req_ready !== 2'b10 && n < 16) begin
                step();
                n++;
            end
            check($sformatf("stream%0d:grant", k), 32'(bus.req_ready), 32'd2);
            if (k > 0) check($sformatf("stream%0d:gap", k), 32'(cyc - last_hs), 32'd3);
            last_hs = cyc;
            step();
            if (k < 3) drive(1, 1'b0, SX[k+1], SY[k+1]);
            else bus.req_valid[1] = 1'b0;
            wait_rsp($sformatf("stream%0d", k), ADD_LAT);
            check_rsp($sformatf("stream%0d", k), 1'b1, SF[k], SO[k], 1'b0);
            accept($sformatf("stream%0d", k));
        end

        // Reset one cycle after a sub handshake drops the op and returns the pointer to 0.
        drive(0, 1'b1, 32'd50, 32'd8);
        handshake("rstmid", 0, 1'b0);
        rst = 1'b1;
        step();
        check("rstmid:rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstmid:rsp_f",     bus.rsp_f,          32'd0);
        check("rstmid:rsp_ovf",   32'(bus.rsp_ovf),   32'd0);
        check("rstmid:rsp_zero",  32'(bus.rsp_zero),  32'd0);
        check("rstmid:rsp_id",    32'(bus.rsp_id),    32'd0);
        check("rstmid:req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        drive(0, 1'b0, 32'd2, 32'd3);
        drive(1, 1'b0, 32'd9, 32'd9);
        handshake("rstptr", 0, 1'b0);
        bus.req_valid[1] = 1'b0;
        wait_rsp("rstptr", ADD_LAT);
        check_rsp("rstptr", 1'b0, 32'd5, 1'b0, 1'b0);
        accept("rstptr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
